// File: rtl/pmu_pkg.sv
// -----------------------------------------------------------------------------
// pmu_pkg
// Shared types and default constants for the PMU power-domain request path.
//   pd_sched_state_e : scheduler FSM states
//   PD_ID_W / pd_id_t: power-domain identifier (fixed 4 bits)
//   SEQ_GAP_DEF      : default idle cycles after each completed command
//   ACK_TIMEOUT_DEF  : default cycles to wait for a controller ack
// -----------------------------------------------------------------------------
package pmu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        WAIT_ACK = 2'd2,
        GAP      = 2'd3
    } pd_sched_state_e;

    localparam int PD_ID_W = 4;

    typedef logic [PD_ID_W-1:0] pd_id_t;

    localparam int SEQ_GAP_DEF     = 50;
    localparam int ACK_TIMEOUT_DEF = 1023;

endpackage : pmu_pkg

// File: rtl/pd_rr_arbiter.sv
// -----------------------------------------------------------------------------
// pd_rr_arbiter
// Combinational round-robin grant selection. The winner is the first asserted
// request at or after rr_ptr, wrapping around. The pointer register itself
// lives in the parent.
//   req_valid   in  NUM_REQ  pending requests
//   rr_ptr      in  PTR_W    index with highest priority this round
//   grant_valid out 1        at least one request is pending
//   grant_idx   out PTR_W    index of the winning requester
// -----------------------------------------------------------------------------
module pd_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic               grant_valid,
    output logic [PTR_W-1:0]   grant_idx
);

    // Walk the offsets from farthest to nearest so the nearest hit is the last
    // one written and therefore wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = {PTR_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int   idx_v;
            logic hit_v;
            idx_v       = (int'(rr_ptr) + i) % NUM_REQ;
            hit_v       = req_valid[PTR_W'(idx_v)];
            grant_valid = grant_valid | hit_v;
            grant_idx   = hit_v ? PTR_W'(idx_v) : grant_idx;
        end
    end

endmodule : pd_rr_arbiter

// File: rtl/pd_request_scheduler.sv
// -----------------------------------------------------------------------------
// pd_request_scheduler
// Serialises power-domain on/off requests from NUM_REQ requesters into a
// single valid/ack command stream toward the power domain controller. One
// command is outstanding at a time; a minimum idle gap follows every issued
// command and an ack timeout aborts a stalled one. A shadow of every domain's
// state suppresses redundant commands.
//   clk, rstn      clock, asynchronous active-low reset
//   req_valid/req_pd_id/req_on  per-requester request (id r at [4r+3:4r])
//   req_ready      one-cycle accept pulse to the granted requester
//   rsp_valid/rsp_err           one-cycle completion pulse (+ failure flag)
//   cmd_valid/cmd_pd_id/cmd_on  command to the controller, held until ack
//   cmd_ack/cmd_err             controller completion (+ failure flag)
//   err_clr        clears timeout_err
//   pd_state       shadow of the domain states (1 = on)
//   timeout_err    sticky ack-timeout flag
//   busy           scheduler is not idle
// All outputs are registered.
// -----------------------------------------------------------------------------
module pd_request_scheduler
    import pmu_pkg::*;
#(
    parameter int                NUM_PD         = 10,
    parameter int                NUM_REQ        = 4,
    parameter int                SEQ_GAP        = SEQ_GAP_DEF,
    parameter int                ACK_TIMEOUT    = ACK_TIMEOUT_DEF,
    parameter logic [NUM_PD-1:0] PD_RESET_STATE = {NUM_PD{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*PD_ID_W-1:0] req_pd_id,
    input  logic [NUM_REQ-1:0]         req_on,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic                       rsp_err,
    output logic                       cmd_valid,
    output logic [PD_ID_W-1:0]         cmd_pd_id,
    output logic                       cmd_on,
    input  logic                       cmd_ack,
    input  logic                       cmd_err,
    input  logic                       err_clr,
    output logic [NUM_PD-1:0]          pd_state,
    output logic                       timeout_err,
    output logic                       busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [PD_ID_W:0] pd_lim_t;

    localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = (SEQ_GAP > 0) ? 16'(SEQ_GAP - 1) : 16'd0;
    localparam pd_lim_t     PD_LIMIT = pd_lim_t'(NUM_PD);

    pd_sched_state_e     state_r, state_s;
    logic [PTR_W-1:0]    rr_ptr_r, rr_ptr_s;
    logic [PTR_W-1:0]    win_idx_r, win_idx_s;
    pd_id_t              win_pd_r, win_pd_s;
    logic                win_on_r, win_on_s;
    logic [15:0]         timer_r, timer_s;
    logic [NUM_REQ-1:0]  req_ready_r, req_ready_s;
    logic [NUM_REQ-1:0]  rsp_valid_r, rsp_valid_s;
    logic                rsp_err_r, rsp_err_s;
    logic                cmd_valid_r, cmd_valid_s;
    pd_id_t              cmd_pd_id_r, cmd_pd_id_s;
    logic                cmd_on_r, cmd_on_s;
    logic [NUM_PD-1:0]   pd_state_r, pd_state_s;
    logic                timeout_err_r, timeout_err_s;
    logic                busy_r, busy_s;

    logic                grant_valid_s;
    logic [PTR_W-1:0]    grant_idx_s;
    pd_id_t              grant_pd_s;
    logic                grant_on_s;
    logic [NUM_REQ-1:0]  grant_onehot_s;
    logic [NUM_REQ-1:0]  win_onehot_s;
    logic                cur_on_s;
    logic                pd_ok_s;
    logic [NUM_PD-1:0]   pd_upd_s;
    logic                timeout_set_s;

    pd_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr_r),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Mux the arbiter winner's payload and one-hot ready vector.
    always_comb begin
        grant_pd_s     = {PD_ID_W{1'b0}};
        grant_on_s     = 1'b0;
        grant_onehot_s = {NUM_REQ{1'b0}};
        for (int r = 0; r < NUM_REQ; r++) begin
            logic sel_v;
            sel_v             = (grant_idx_s == PTR_W'(r));
            grant_onehot_s[r] = sel_v;
            grant_pd_s        = grant_pd_s | (sel_v ? req_pd_id[r*PD_ID_W +: PD_ID_W] : {PD_ID_W{1'b0}});
            grant_on_s        = grant_on_s | (sel_v & req_on[r]);
        end
    end

    // Decode the latched winner: response vector, current shadow state of its
    // domain, and the shadow as it would look after a successful command.
    always_comb begin
        win_onehot_s = {NUM_REQ{1'b0}};
        cur_on_s     = 1'b0;
        pd_upd_s     = pd_state_r;
        pd_ok_s      = ({1'b0, win_pd_r} < PD_LIMIT);
        for (int r = 0; r < NUM_REQ; r++) begin
            win_onehot_s[r] = (win_idx_r == PTR_W'(r));
        end
        for (int i = 0; i < NUM_PD; i++) begin
            cur_on_s    = cur_on_s | (pd_state_r[i] & (win_pd_r == PD_ID_W'(i)));
            pd_upd_s[i] = (win_pd_r == PD_ID_W'(i)) ? win_on_r : pd_state_r[i];
        end
    end

    // Next-state and next-output logic of the scheduler FSM.
    always_comb begin
        state_s       = state_r;
        rr_ptr_s      = rr_ptr_r;
        win_idx_s     = win_idx_r;
        win_pd_s      = win_pd_r;
        win_on_s      = win_on_r;
        timer_s       = timer_r;
        req_ready_s   = {NUM_REQ{1'b0}};
        rsp_valid_s   = {NUM_REQ{1'b0}};
        rsp_err_s     = 1'b0;
        cmd_valid_s   = cmd_valid_r;
        cmd_pd_id_s   = cmd_pd_id_r;
        cmd_on_s      = cmd_on_r;
        pd_state_s    = pd_state_r;
        timeout_set_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    win_idx_s   = grant_idx_s;
                    win_pd_s    = grant_pd_s;
                    win_on_s    = grant_on_s;
                    req_ready_s = grant_onehot_s;
                    rr_ptr_s    = (grant_idx_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}}
                                                                       : grant_idx_s + PTR_W'(1);
                    state_s     = CHECK;
                end else begin
                    state_s = IDLE;
                end
            end
            CHECK: begin
                if (!pd_ok_s) begin
                    rsp_valid_s = win_onehot_s;
                    rsp_err_s   = 1'b1;
                    state_s     = IDLE;
                end else if (cur_on_s == win_on_r) begin
                    // Domain already in the requested state: answer without a command.
                    rsp_valid_s = win_onehot_s;
                    state_s     = IDLE;
                end else begin
                    cmd_valid_s = 1'b1;
                    cmd_pd_id_s = win_pd_r;
                    cmd_on_s    = win_on_r;
                    timer_s     = 16'd0;
                    state_s     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // An ack on the final timeout cycle is still a normal completion.
                if (cmd_ack) begin
                    cmd_valid_s = 1'b0;
                    pd_state_s  = cmd_err ? pd_state_r : pd_upd_s;
                    rsp_valid_s = win_onehot_s;
                    rsp_err_s   = cmd_err;
                    timer_s     = 16'd0;
                    state_s     = GAP;
                end else if (timer_r == ACK_LAST) begin
                    cmd_valid_s   = 1'b0;
                    rsp_valid_s   = win_onehot_s;
                    rsp_err_s     = 1'b1;
                    timeout_set_s = 1'b1;
                    timer_s       = 16'd0;
                    state_s       = GAP;
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end
            GAP: begin
                if (timer_r >= GAP_LAST) begin
                    timer_s = 16'd0;
                    state_s = IDLE;
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end
            default: begin
                cmd_valid_s = 1'b0;
                timer_s     = 16'd0;
                state_s     = IDLE;
            end
        endcase

        // A new timeout outranks a simultaneous clear.
        if (timeout_set_s) begin
            timeout_err_s = 1'b1;
        end else if (err_clr) begin
            timeout_err_s = 1'b0;
        end else begin
            timeout_err_s = timeout_err_r;
        end

        busy_s = (state_s != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= IDLE;
            rr_ptr_r      <= {PTR_W{1'b0}};
            win_idx_r     <= {PTR_W{1'b0}};
            win_pd_r      <= {PD_ID_W{1'b0}};
            win_on_r      <= 1'b0;
            timer_r       <= 16'd0;
            req_ready_r   <= {NUM_REQ{1'b0}};
            rsp_valid_r   <= {NUM_REQ{1'b0}};
            rsp_err_r     <= 1'b0;
            cmd_valid_r   <= 1'b0;
            cmd_pd_id_r   <= {PD_ID_W{1'b0}};
            cmd_on_r      <= 1'b0;
            pd_state_r    <= PD_RESET_STATE;
            timeout_err_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            rr_ptr_r      <= rr_ptr_s;
            win_idx_r     <= win_idx_s;
            win_pd_r      <= win_pd_s;
            win_on_r      <= win_on_s;
            timer_r       <= timer_s;
            req_ready_r   <= req_ready_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_err_r     <= rsp_err_s;
            cmd_valid_r   <= cmd_valid_s;
            cmd_pd_id_r   <= cmd_pd_id_s;
            cmd_on_r      <= cmd_on_s;
            pd_state_r    <= pd_state_s;
            timeout_err_r <= timeout_err_s;
            busy_r        <= busy_s;
        end
    end

    assign req_ready   = req_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_err     = rsp_err_r;
    assign cmd_valid   = cmd_valid_r;
    assign cmd_pd_id   = cmd_pd_id_r;
    assign cmd_on      = cmd_on_r;
    assign pd_state    = pd_state_r;
    assign timeout_err = timeout_err_r;
    assign busy        = busy_r;

endmodule : pd_request_scheduler

// File: tb/tb_pd_request_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pd_request_scheduler
// Directed self-checking bench for pd_request_scheduler. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_pd_request_scheduler;

    localparam int        NUM_PD      = 10;
    localparam int        NUM_REQ     = 4;
    localparam int        SEQ_GAP     = 50;
    localparam int        ACK_TIMEOUT = 16;
    localparam logic [9:0] PD_RST     = 10'h200;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  req_valid = 4'h0;
    logic [15:0] req_pd_id = 16'h0000;
    logic [3:0]  req_on = 4'h0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic        rsp_err;
    logic        cmd_valid;
    logic [3:0]  cmd_pd_id;
    logic        cmd_on;
    logic        cmd_ack = 1'b0;
    logic        cmd_err = 1'b0;
    logic        err_clr = 1'b0;
    logic [9:0]  pd_state;
    logic        timeout_err;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ack_cyc = 0;
    int cmd_cyc = 0;
    int prev_ack = 0;
    int waited = 0;
    int seen = 0;

    pd_request_scheduler #(
        .NUM_PD         (NUM_PD),
        .NUM_REQ        (NUM_REQ),
        .SEQ_GAP        (SEQ_GAP),
        .ACK_TIMEOUT    (ACK_TIMEOUT),
        .PD_RESET_STATE (PD_RST)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_pd_id   (req_pd_id),
        .req_on      (req_on),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .cmd_valid   (cmd_valid),
        .cmd_pd_id   (cmd_pd_id),
        .cmd_on      (cmd_on),
        .cmd_ack     (cmd_ack),
        .cmd_err     (cmd_err),
        .err_clr     (err_clr),
        .pd_state    (pd_state),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_req(input int idx, input logic [3:0] pd, input logic on);
        req_pd_id = (req_pd_id & ~(16'hF << (idx * 4))) | ({12'h000, pd} << (idx * 4));
        req_on    = on ? (req_on | (4'b0001 << idx)) : (req_on & ~(4'b0001 << idx));
        req_valid = req_valid | (4'b0001 << idx);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " req_ready"}, 32'(req_ready), 32'h0);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, " rsp_err"}, 32'(rsp_err), 32'h0);
        check({tag, " cmd_valid"}, 32'(cmd_valid), 32'h0);
        check({tag, " cmd_pd_id"}, 32'(cmd_pd_id), 32'h0);
        check({tag, " cmd_on"}, 32'(cmd_on), 32'h0);
        check({tag, " timeout_err"}, 32'(timeout_err), 32'h0);
        check({tag, " pd_state"}, 32'(pd_state), 32'(PD_RST));
        check({tag, " busy"}, 32'(busy), 32'h0);
    endtask

    // Wait (bounded) for a grant, check it went to idx, then withdraw the request.
    task automatic wait_ready(input int idx, input string tag);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (req_ready == 4'h0 && waited < 300);
        check({tag, " req_ready"}, 32'(req_ready), 32'h1 << idx);
        req_valid = req_valid & ~(4'b0001 << idx);
    endtask

    task automatic run_cmd(input int idx, input logic [3:0] pd, input logic on,
                           input int delay, input logic err, input string tag);
        wait_ready(idx, tag);
        tick();
        cmd_cyc = cyc;
        check({tag, " cmd_valid"}, 32'(cmd_valid), 32'h1);
        check({tag, " cmd_pd_id"}, 32'(cmd_pd_id), 32'(pd));
        check({tag, " cmd_on"}, 32'(cmd_on), 32'(on));
        check({tag, " ready_drop"}, 32'(req_ready), 32'h0);
        tick_n(delay);
        check({tag, " cmd_held"}, 32'(cmd_valid), 32'h1);
        cmd_ack = 1'b1;
        cmd_err = err;
        tick();
        cmd_ack = 1'b0;
        cmd_err = 1'b0;
        ack_cyc = cyc;
        check({tag, " cmd_drop"}, 32'(cmd_valid), 32'h0);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'h1 << idx);
        check({tag, " rsp_err"}, 32'(rsp_err), 32'(err));
    endtask

    task automatic run_nocmd(input int idx, input logic err, input string tag);
        wait_ready(idx, tag);
        tick();
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'h1 << idx);
        check({tag, " rsp_err"}, 32'(rsp_err), 32'(err));
        check({tag, " no_cmd"}, 32'(cmd_valid), 32'h0);
        check({tag, " no_gap"}, 32'(busy), 32'h0);
    endtask

    task automatic run_timeout(input int idx, input logic [3:0] pd, input logic clr, input string tag);
        int hi;
        wait_ready(idx, tag);
        tick();
        check({tag, " cmd_valid"}, 32'(cmd_valid), 32'h1);
        check({tag, " cmd_pd_id"}, 32'(cmd_pd_id), 32'(pd));
        hi = 0;
        for (int k = 0; k < ACK_TIMEOUT - 1; k++) begin
            tick();
            if (cmd_valid) hi++;
        end
        check({tag, " held_cycles"}, 32'(hi), 32'(ACK_TIMEOUT - 1));
        err_clr = clr;
        tick();
        err_clr = 1'b0;
        check({tag, " cmd_drop"}, 32'(cmd_valid), 32'h0);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'h1 << idx);
        check({tag, " rsp_err"}, 32'(rsp_err), 32'h1);
        check({tag, " timeout_err"}, 32'(timeout_err), 32'h1);
    endtask

    initial begin
        // Reset values
        #12;
        check_reset("rst");
        tick_n(2);
        rstn = 1'b1;
        tick();

        // Single on: r0 -> pd3 on, ack after 12 cycles of cmd_valid
        set_req(0, 4'd3, 1'b1);
        run_cmd(0, 4'd3, 1'b1, 11, 1'b0, "single");
        check("single pd_state", 32'(pd_state), 32'h208);
        check("single busy_in_gap", 32'(busy), 32'h1);
        tick();
        check("single rsp_pulse", 32'(rsp_valid), 32'h0);
        tick_n(SEQ_GAP - 2);
        check("single busy_last_gap", 32'(busy), 32'h1);
        tick();
        check("single busy_clear", 32'(busy), 32'h0);

        // Reset between tests restarts round-robin from requester 0
        rstn = 1'b0;
        #1;
        check("rst2 pd_state", 32'(pd_state), 32'(PD_RST));
        tick();
        rstn = 1'b1;
        tick();

        // Round-robin: all four requesters, immediate acks
        req_pd_id = 16'h3210;
        req_on    = 4'hF;
        req_valid = 4'hF;
        run_cmd(0, 4'd0, 1'b1, 0, 1'b0, "rr0");
        prev_ack = ack_cyc;
        run_cmd(1, 4'd1, 1'b1, 0, 1'b0, "rr1");
        check("rr gap1", 32'(cmd_cyc - prev_ack), 32'(SEQ_GAP + 2));
        prev_ack = ack_cyc;
        run_cmd(2, 4'd2, 1'b1, 0, 1'b0, "rr2");
        check("rr gap2", 32'(cmd_cyc - prev_ack), 32'(SEQ_GAP + 2));
        prev_ack = ack_cyc;
        run_cmd(3, 4'd3, 1'b1, 0, 1'b0, "rr3");
        check("rr gap3", 32'(cmd_cyc - prev_ack), 32'(SEQ_GAP + 2));
        check("rr pd_state", 32'(pd_state), 32'h20F);
        set_req(0, 4'd0, 1'b0);
        set_req(2, 4'd2, 1'b0);
        run_cmd(0, 4'd0, 1'b0, 0, 1'b0, "rr0b");
        prev_ack = ack_cyc;
        run_cmd(2, 4'd2, 1'b0, 0, 1'b0, "rr2b");
        check("rr gap4", 32'(cmd_cyc - prev_ack), 32'(SEQ_GAP + 2));
        check("rr2b pd_state", 32'(pd_state), 32'h20A);

        // Redundant (pd5 already off) and invalid (pd12) requests: no command, no gap
        set_req(1, 4'd5, 1'b0);
        run_nocmd(1, 1'b0, "redundant");
        set_req(3, 4'd12, 1'b1);
        run_nocmd(3, 1'b1, "invalid");
        check("invalid grant_latency", 32'(waited), 32'h1);
        check("nocmd pd_state", 32'(pd_state), 32'h20A);

        // Controller error on pd7 on: shadow unchanged
        set_req(2, 4'd7, 1'b1);
        run_cmd(2, 4'd7, 1'b1, 3, 1'b1, "ctrl_err");
        check("ctrl_err pd_state", 32'(pd_state), 32'h20A);
        waited = 0;
        while (busy && waited < 200) begin
            tick();
            waited++;
        end
        check("idle before stray", 32'(busy), 32'h0);

        // Stray ack while idle is ignored
        cmd_ack = 1'b1;
        cmd_err = 1'b1;
        tick();
        cmd_ack = 1'b0;
        cmd_err = 1'b0;
        check("stray rsp_valid", 32'(rsp_valid), 32'h0);
        check("stray busy", 32'(busy), 32'h0);
        tick();
        check("stray rsp_valid2", 32'(rsp_valid), 32'h0);
        check("stray pd_state", 32'(pd_state), 32'h20A);

        // Ack on the last cycle before timeout wins
        set_req(0, 4'd6, 1'b1);
        run_cmd(0, 4'd6, 1'b1, ACK_TIMEOUT - 1, 1'b0, "late_ack");
        check("late_ack timeout_err", 32'(timeout_err), 32'h0);
        check("late_ack pd_state", 32'(pd_state), 32'h24A);

        // Timeout, stickiness, set-beats-clear, then clear
        set_req(1, 4'd8, 1'b1);
        run_timeout(1, 4'd8, 1'b0, "to1");
        check("to1 pd_state", 32'(pd_state), 32'h24A);
        tick_n(3);
        check("to1 sticky", 32'(timeout_err), 32'h1);
        set_req(3, 4'd9, 1'b0);
        run_timeout(3, 4'd9, 1'b1, "to2_clr");
        check("to2 pd_state", 32'(pd_state), 32'h24A);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", 32'(timeout_err), 32'h0);

        // Reset during WAIT_ACK
        set_req(0, 4'd4, 1'b1);
        waited = 0;
        do begin
            tick();
            waited++;
            if (req_ready[0]) req_valid = req_valid & 4'b1110;
        end while (!cmd_valid && waited < 300);
        check("mid cmd_valid", 32'(cmd_valid), 32'h1);
        tick_n(3);
        #2;
        rstn = 1'b0;
        #1;
        check_reset("mid_rst");
        tick_n(2);
        rstn = 1'b1;
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rsp_valid != 4'h0 || cmd_valid) seen++;
        end
        check("post_rst no_rsp", 32'(seen), 32'h0);
        check("post_rst busy", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pd_request_scheduler
